shk_slave_regbank: RTL and testbench
====================================

# shk_slave_regbank

Downstream consumer of the shk handshake bus: a word-addressed register bank that accepts master requests (valid, msync, maddr, mdata) and answers with ready, ssync, sdata and saddr. Serves as the default bus target for the frame agent and as the reference responder in UVM benches. It has programmable wait states, error flagging for bad addresses, and a transaction counter.

## Interface
- DEPTH, 16, number of 32-bit registers (power of two, 2..256)
- WAIT_CYCLES, 2, wait states inserted between request capture and response (0..15)
- RD_ERR_DATA, 32'hDEAD_BEEF, read data returned on an erroring read
- i_sys_clk  in  1  system clock, all logic on rising edge
- i_sys_rst  in  1  reset, synchronous, active-high
- i_shk_valid  in  1  master request valid
- i_shk_msync  in  1  request type: 1 = write, 0 = read
- i_shk_maddr  in  32  byte address
- i_shk_mdata  in  32  write data
- o_shk_ready  out  1  one-cycle pulse completing the transfer
- o_shk_ssync  out  1  read data valid, asserted with ready on reads only
- o_shk_sdata  out  32  read data
- o_shk_saddr  out  32  echo of captured address
- o_err  out  1  one-cycle pulse with ready when the address is invalid
- o_trans_cnt  out  16  completed transfers, wraps

## Operation
- Address decode: valid when maddr[1:0]==0 and maddr[31:2] < DEPTH. Index = maddr[log2(DEPTH)+1:2].
- FSM states:
  - IDLE: on i_shk_valid=1, capture msync/maddr/mdata into holding registers. Go to WAIT, or go to RESP if WAIT_CYCLES==0.
  - WAIT: a down-counter loaded with WAIT_CYCLES-1 at capture. Go to RESP when it reaches 0.
  - RESP: assert all response outputs for exactly one cycle, then return to IDLE.
- Write (msync=1), valid address: the register is updated in the RESP cycle. ssync=0, sdata=0, err=0.
- Write, invalid address: no register changes. err=1.
- Read (msync=0), valid address: sdata = register content at the RESP cycle. ssync=1.
- Read, invalid address: sdata=RD_ERR_DATA, ssync=1, err=1.
- saddr echoes the captured maddr in RESP for every transfer.
- o_trans_cnt increments by 1 at every RESP, errored transfers included. Wraps from 16'hFFFF to 0.
- Request inputs are sampled only in IDLE. Changes during WAIT or RESP are ignored.
- Dropping valid during WAIT does not abort; the transfer completes.
- The master must deassert valid in the cycle after ready, or present a new request. A valid still high in the cycle after RESP is taken as a new request.

## Timing
- Reset values: o_shk_ready=0, o_shk_ssync=0, o_shk_sdata=0, o_shk_saddr=0, o_err=0, o_trans_cnt=0. FSM returns to IDLE and all DEPTH registers clear to 0.
- Latency: valid first sampled high at edge T → ready high during cycle T+1+WAIT_CYCLES (T+1 when WAIT_CYCLES=0).
- All outputs are registered. Outside the RESP cycle: ready, ssync and err are 0; sdata and saddr return to 0.
- Back-to-back: minimum spacing between ready pulses is WAIT_CYCLES+2 cycles.
- Reset asserted in WAIT or RESP: the transfer is dropped, no write commits, no ready, the counter is not incremented. The next edge after reset deasserts is in IDLE.
- A read issued after a write to the same address observes the written value; there is no hazard because transfers are serialized.

## Test plan
- Reset, then write 0x1234_5678 to addr 0x08 and read addr 0x08 (WAIT_CYCLES=2) → each ready arrives 3 cycles after valid. The read returns sdata=0x1234_5678 with ssync=1 and saddr=0x08. o_trans_cnt=2.
- Read addr 0x40 (DEPTH=16, index 16) → sdata=0xDEAD_BEEF, ssync=1, err=1. Then write 0x1 to 0x42 (misaligned) → err=1, ssync=0, and a read of 0x00 still returns 0.
- WAIT_CYCLES=0 with valid held high for 6 alternating write/read requests → ready on every second cycle, 3 readbacks correct, o_trans_cnt=6.
- Valid dropped one cycle after capture, with maddr/mdata changed during WAIT → the write commits the originally captured data and address.
- Reset asserted mid-WAIT of a write 0xAAAA_AAAA to 0x04 → no ready, o_trans_cnt=0, a subsequent read of 0x04 returns 0.
- Counter preloaded to 0xFFFF via 65535 transfers, then one more → o_trans_cnt wraps to 0x0000.

Source files
------------

// File: rtl/shk_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module   : shk_slave_regbank
// Purpose  : shk bus target. It holds a word-addressed register bank and
//            supports programmable wait states, bad-address error flagging
//            and a count of completed transfers.
// Revision : 1.0 - initial release
// ============================================================================
module shk_slave_regbank #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_shk_valid,
    input  logic        i_shk_msync,
    input  logic [31:0] i_shk_maddr,
    input  logic [31:0] i_shk_mdata,
    output logic        o_shk_ready,
    output logic        o_shk_ssync,
    output logic [31:0] o_shk_sdata,
    output logic [31:0] o_shk_saddr,
    output logic        o_err,
    output logic [15:0] o_trans_cnt
);

    localparam int unsigned c_IDX_W     = $clog2(DEPTH);
    localparam logic [29:0] c_DEPTH     = 30'(DEPTH);
    localparam logic [3:0]  c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_wr;
    logic [31:0]          r_addr;
    logic [31:0]          r_data;
    logic [3:0]           r_wait_cnt;
    logic [31:0]          r_regs [DEPTH];
    logic                 r_ready;
    logic                 r_ssync;
    logic [31:0]          r_sdata;
    logic [31:0]          r_saddr;
    logic                 r_err;
    logic [15:0]          r_trans_cnt;
    logic                 w_addr_ok;
    logic [c_IDX_W-1:0]   w_idx;

    assign w_addr_ok = (r_addr[1:0] == 2'b00) && (r_addr[31:2] < c_DEPTH);
    assign w_idx     = r_addr[c_IDX_W+1:2];

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_shk_valid) begin
                    w_next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request fields are latched once in IDLE so the master may change them freely afterwards
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_wr       <= 1'b0;
            r_addr     <= 32'd0;
            r_data     <= 32'd0;
            r_wait_cnt <= 4'd0;
        end else if ((r_state == S_IDLE) && i_shk_valid) begin
            r_wr       <= i_shk_msync;
            r_addr     <= i_shk_maddr;
            r_data     <= i_shk_mdata;
            r_wait_cnt <= c_WAIT_LOAD;
        end else if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_ready     <= 1'b0;
            r_ssync     <= 1'b0;
            r_sdata     <= 32'd0;
            r_saddr     <= 32'd0;
            r_err       <= 1'b0;
            r_trans_cnt <= 16'd0;
        end else begin
            r_ready <= 1'b0;
            r_ssync <= 1'b0;
            r_sdata <= 32'd0;
            r_saddr <= 32'd0;
            r_err   <= 1'b0;
            if (r_state == S_RESP) begin
                r_ready     <= 1'b1;
                r_saddr     <= r_addr;
                r_err       <= !w_addr_ok;
                r_trans_cnt <= r_trans_cnt + 16'd1;
                if (r_wr) begin
                    if (w_addr_ok) begin
                        r_regs[w_idx] <= r_data;
                    end
                end else begin
                    r_ssync <= 1'b1;
                    r_sdata <= w_addr_ok ? r_regs[w_idx] : RD_ERR_DATA;
                end
            end
        end
    end

    assign o_shk_ready = r_ready;
    assign o_shk_ssync = r_ssync;
    assign o_shk_sdata = r_sdata;
    assign o_shk_saddr = r_saddr;
    assign o_err       = r_err;
    assign o_trans_cnt = r_trans_cnt;

endmodule
`default_nettype wire

// File: tb/tb_shk_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_shk_slave_regbank
// Purpose  : Self-checking bench for two regbank instances (WAIT_CYCLES=2
//            and WAIT_CYCLES=0) against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shk_slave_regbank;

    logic             clk = 1'b0;
    logic [1:0]       rst;
    logic [1:0]       valid;
    logic [1:0]       msync;
    logic [1:0][31:0] maddr;
    logic [1:0][31:0] mdata;
    logic [1:0]       ready;
    logic [1:0]       ssync;
    logic [1:0][31:0] sdata;
    logic [1:0][31:0] saddr;
    logic [1:0]       err;
    logic [1:0][15:0] cnt;

    logic [31:0] model [2][16];
    logic [15:0] mcnt  [2];
    int          waits [2] = '{2, 0};
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    shk_slave_regbank #(.DEPTH(16), .WAIT_CYCLES(2), .RD_ERR_DATA(32'hDEAD_BEEF)) dut_a (
        .i_sys_clk(clk), .i_sys_rst(rst[0]), .i_shk_valid(valid[0]), .i_shk_msync(msync[0]),
        .i_shk_maddr(maddr[0]), .i_shk_mdata(mdata[0]), .o_shk_ready(ready[0]),
        .o_shk_ssync(ssync[0]), .o_shk_sdata(sdata[0]), .o_shk_saddr(saddr[0]),
        .o_err(err[0]), .o_trans_cnt(cnt[0]));

    shk_slave_regbank #(.DEPTH(16), .WAIT_CYCLES(0), .RD_ERR_DATA(32'hDEAD_BEEF)) dut_b (
        .i_sys_clk(clk), .i_sys_rst(rst[1]), .i_shk_valid(valid[1]), .i_shk_msync(msync[1]),
        .i_shk_maddr(maddr[1]), .i_shk_mdata(mdata[1]), .o_shk_ready(ready[1]),
        .o_shk_ssync(ssync[1]), .o_shk_sdata(sdata[1]), .o_shk_saddr(saddr[1]),
        .o_err(err[1]), .o_trans_cnt(cnt[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] addr);
        return (addr % 4 == 0) && (addr / 4 < 16);
    endfunction

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel < 2)       return 32'($urandom_range(0, 15)) * 4;
        else if (sel == 2) return ($urandom & ~32'h3) | 32'h40;
        else               return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
    endfunction

    task automatic model_reset(input int w);
        for (int i = 0; i < 16; i++) model[w][i] = 32'd0;
        mcnt[w] = 16'd0;
    endtask

    task automatic do_reset(input int w);
        @(negedge clk);
        rst[w]   = 1'b1;
        valid[w] = 1'b0;
        repeat (2) @(negedge clk);
        rst[w] = 1'b0;
        model_reset(w);
    endtask

    // Score a response cycle against the model and advance the model
    task automatic score(input int w, input string tag, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        logic        ok;
        logic [31:0] exp_sd;
        ok     = addr_ok(addr);
        exp_sd = wr ? 32'd0 : (ok ? model[w][addr / 4] : 32'hDEAD_BEEF);
        mcnt[w] = mcnt[w] + 16'd1;
        chk({tag, "_ready"}, 32'(ready[w]), 32'd1);
        chk({tag, "_ssync"}, 32'(ssync[w]), 32'(!wr));
        chk({tag, "_sdata"}, sdata[w], exp_sd);
        chk({tag, "_saddr"}, saddr[w], addr);
        chk({tag, "_err"},   32'(err[w]), 32'(!ok));
        chk({tag, "_cnt"},   32'(cnt[w]), 32'(mcnt[w]));
        if (wr && ok) model[w][addr / 4] = data;
    endtask

    task automatic xfer(input int w, input string tag, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data);
        int lat;
        @(negedge clk);
        valid[w] = 1'b1;
        msync[w] = wr;
        maddr[w] = addr;
        mdata[w] = data;
        @(posedge clk);
        @(negedge clk);
        valid[w] = 1'b0;
        msync[w] = 1'($urandom);
        maddr[w] = $urandom;
        mdata[w] = $urandom;
        lat = 0;
        while (ready[w] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(waits[w] + 1));
        score(w, tag, wr, addr, data);
        @(negedge clk);
        chk({tag, "_idle_ready"}, 32'(ready[w]), 32'd0);
        chk({tag, "_idle_sdata"}, sdata[w], 32'd0);
        chk({tag, "_idle_saddr"}, saddr[w], 32'd0);
        chk({tag, "_idle_err"},   32'(err[w]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int          pulses;
        logic [31:0] a, d, last_addr;
        logic        wr;

        rst   = 2'b11;
        valid = 2'b00;
        msync = 2'b00;
        maddr = '0;
        mdata = '0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk("rst_ready", 32'(ready[w]), 32'd0);
            chk("rst_ssync", 32'(ssync[w]), 32'd0);
            chk("rst_sdata", sdata[w], 32'd0);
            chk("rst_saddr", saddr[w], 32'd0);
            chk("rst_err",   32'(err[w]), 32'd0);
            chk("rst_cnt",   32'(cnt[w]), 32'd0);
        end
        rst = 2'b00;
        model_reset(0);
        model_reset(1);

        xfer(0, "wr08", 1'b1, 32'h08, 32'h1234_5678);
        xfer(0, "rd08", 1'b0, 32'h08, 32'h0);
        chk("cnt_two", 32'(cnt[0]), 32'd2);

        xfer(0, "rd40",  1'b0, 32'h40, 32'h0);
        xfer(0, "wr42",  1'b1, 32'h42, 32'h1);
        xfer(0, "rd00",  1'b0, 32'h00, 32'h0);

        // Request inputs are scrambled by xfer right after capture
        xfer(0, "wrdrop", 1'b1, 32'h1C, 32'hCAFE_F00D);
        xfer(0, "rddrop", 1'b0, 32'h1C, 32'h0);

        for (int i = 0; i < 30; i++) begin
            a = rand_addr();
            xfer(0, "rndA", 1'($urandom), a, $urandom);
        end

        // Reset while the write is still in its wait states
        @(negedge clk);
        valid[0] = 1'b1;
        msync[0] = 1'b1;
        maddr[0] = 32'h04;
        mdata[0] = 32'hAAAA_AAAA;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        rst[0]   = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        model_reset(0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready[0] === 1'b1) pulses++;
        end
        chk("rstwait_pulses", 32'(pulses), 32'd0);
        chk("rstwait_cnt", 32'(cnt[0]), 32'd0);
        xfer(0, "rstwait_rd04", 1'b0, 32'h04, 32'h0);

        // Zero wait states, valid held high across six alternating requests
        do_reset(1);
        last_addr = 32'h0;
        for (int i = 0; i < 6; i++) begin
            wr = (i % 2 == 0);
            if (wr) last_addr = 32'($urandom_range(0, 15)) * 4;
            d = $urandom;
            valid[1] = 1'b1;
            msync[1] = wr;
            maddr[1] = last_addr;
            mdata[1] = d;
            @(posedge clk);
            @(negedge clk);
            chk("b2b_gap", 32'(ready[1]), 32'd0);
            @(negedge clk);
            score(1, "b2b", wr, last_addr, d);
        end
        valid[1] = 1'b0;
        chk("b2b_cnt", 32'(cnt[1]), 32'd6);

        for (int i = 0; i < 30; i++) begin
            a = rand_addr();
            xfer(1, "rndB", 1'($urandom), a, $urandom);
        end

        // Counter preload stands in for 65534 transfers
        @(negedge clk);
        force dut_b.r_trans_cnt = 16'hFFFE;
        #1;
        release dut_b.r_trans_cnt;
        mcnt[1] = 16'hFFFE;
        chk("preload_cnt", 32'(cnt[1]), 32'h0000_FFFE);
        xfer(1, "wrap1", 1'b1, 32'h10, 32'h5555_0001);
        xfer(1, "wrap2", 1'b0, 32'h10, 32'h0);
        chk("wrap_cnt", 32'(cnt[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
